// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and the operand-signedness decode.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } mdu_state_e;

  // Returns {a_signed, b_signed} for the given operation.
  function automatic logic [1:0] op_signed(input mdu_op_e op);
    logic [1:0] s;
    s = 2'b00;
    unique case (op)
      OP_MULH, OP_DIV, OP_REM: s = 2'b11;
      OP_MULHSU:               s = 2'b10;
      default:                 s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle through a shared 2*XLEN
// shift register (shift-add multiply, restoring divide), start/busy/done handshake.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_in;
  logic [2*XLEN-1:0] acc_q, acc_step, prod;
  logic [XLEN-1:0]   opd_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, calc_result, fast_result;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rmd;
  logic [1:0]        sgn;
  logic              a_neg, b_neg, is_div, div_zero, div_ovf, fast;
  logic              accept, last_iter;
  logic [XLEN:0]     mul_sum, div_diff;
  logic              div_keep;

  always_comb begin
    op_in    = mdu_op_e'(op_i);
    sgn      = op_signed(op_in);
    a_neg    = sgn[1] & operand_a_i[XLEN-1];
    b_neg    = sgn[0] & operand_b_i[XLEN-1];
    a_mag    = a_neg ? -operand_a_i : operand_a_i;
    b_mag    = b_neg ? -operand_b_i : operand_b_i;
    neg_d    = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    is_div   = op_i[2];
    div_zero = is_div && (operand_b_i == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
               (operand_a_i == MOST_NEG) && (operand_b_i == '1);
    fast     = div_zero || div_ovf;
    fast_result = '0;
    if (div_zero)
      fast_result = (op_in == OP_REM || op_in == OP_REMU) ? operand_a_i : '1;
    else if (div_ovf)
      fast_result = (op_in == OP_REM) ? '0 : operand_a_i;
  end

  // Divide step keeps a XLEN+1-bit view of the shifted remainder: the bit
  // shifted out of the top forces the trial subtract to succeed.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_diff = {1'b0, acc_q[2*XLEN-2:XLEN-1]} - {1'b0, opd_q};
    div_keep = acc_q[2*XLEN-1] | ~div_diff[XLEN];
    if (op_q[2])
      acc_step = div_keep ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                          : {acc_q[2*XLEN-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quo  = acc_step[XLEN-1:0];
    rmd  = acc_step[2*XLEN-1:XLEN];
    calc_result = '0;
    unique case (op_q)
      OP_MUL:                       calc_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod[2*XLEN-1:XLEN];
      OP_DIV:                       calc_result = neg_q ? -quo : quo;
      OP_DIVU:                      calc_result = quo;
      OP_REM:                       calc_result = neg_q ? -rmd : rmd;
      OP_REMU:                      calc_result = rmd;
      default:                      calc_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_iter = (cnt_q == CW'(XLEN-1));
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = fast ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC:  state_d = last_iter ? S_DONE : S_CALC;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_in;
        cnt_q <= '0;
        neg_q <= neg_d;
        acc_q <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        opd_q <= is_div ? b_mag : a_mag;
        if (fast)
          result_q <= fast_result;
      end else if (state_q == S_CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CW'(1);
        if (last_iter)
          result_q <= calc_result;
      end
    end
  end

  assign busy_o   = (state_q == S_CALC);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes reference results and expected
// completion cycles; a negedge monitor checks busy/done/result every cycle.
module tb_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  mdu_iter #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    bit          fast;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32M rules computed with plain wide arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        pu;
    logic signed [63:0] ps, psu;
    int                 ia, ib;
    bit                 ovf;
    pu  = {32'b0, a} * {32'b0, b};
    ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    psu = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return pu[31:0];
      3'd1: return ps[63:32];
      3'd2: return psu[63:32];
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every cycle compares handshake and result against the scoreboard.
  always @(negedge clk_i) begin
    if (cyc > 0) begin
      bit          exp_done, exp_busy;
      logic [31:0] exp_r;
      if (rst_i) begin
        q.delete();
        last_res = '0;
      end
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      exp_done = (q.size() > 0) && (q[0].cyc == cyc);
      exp_busy = (q.size() > 0) && !q[0].fast && (q[0].cyc > cyc) && (q[0].cyc - cyc <= 32);
      exp_r    = exp_done ? q[0].res : last_res;
      check("done", 32'(done_o), 32'(exp_done));
      check("busy", 32'(busy_o), 32'(exp_busy));
      check("result", result_o, exp_r);
      if (exp_done) begin
        last_res = q[0].res;
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   fast;
    fast = op[2] && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    e.res  = ref_res(op, a, b);
    e.fast = fast;
    e.cyc  = cyc + (fast ? 1 : 33);
    q.push_back(e);
    start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
    @(negedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(negedge clk_i); #1;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done_o; i++) begin
      @(negedge clk_i); #1;
    end
    if (!done_o) begin
      miscompares++;
      $display("FAIL done_timeout: done_o %b expected 1", done_o);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    wait_idle();
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 15));
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = '0; operand_a_i = '0; operand_b_i = '0;
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i); #1;

    run(3'd0, 32'd7,         32'hFFFF_FFFD);
    run(3'd1, 32'h8000_0000, 32'h8000_0000);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd4, 32'hFFFF_FFF9, 32'd2);
    run(3'd6, 32'hFFFF_FFF9, 32'd2);
    run(3'd5, 32'd100,       32'd7);
    run(3'd7, 32'd100,       32'd7);
    run(3'd4, 32'd5,         32'd0);
    run(3'd7, 32'd5,         32'd0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // start pulse during CALC must be ignored
    drive(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (3) @(negedge clk_i);
    #1 start_i = 1'b1; op_i = 3'd5; operand_a_i = 32'd1; operand_b_i = 32'd1;
    @(negedge clk_i); #1 start_i = 1'b0;
    wait_idle();

    // reset mid-operation: aborted, no done afterwards
    drive(3'd0, 32'd3, 32'd5);
    repeat (8) @(negedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i); #1 rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    #1;

    // back-to-back: second start issued in the DONE cycle
    drive(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done();
    drive(3'd4, 32'hFFFF_0000, 32'd3);
    wait_idle();

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      drive(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        wait_done();
        op = 3'($urandom_range(0, 7));
        drive(op, $urandom, rand_opnd());
      end
      wait_idle();
    end

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
